mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage ARM pipeline, directly downstream of the execute stage.
- Contains the EXE/MEM pipeline register, which captures the ALU result, store value, destination register and the MEM_R/MEM_W/WB enables.
- Performs word loads and stores against an internal data memory with a fixed, configurable access latency, and drives the MEM/WB register.
- Asserts a not-ready signal that freezes all upstream stages while an access is in flight.

Parameters:
- WAIT_CYCLES, 3: extra access cycles per load/store (0 allowed).
- MEM_DEPTH, 64: data memory depth in 32-bit words (power of 2).
- BASE_ADDR, 1024: byte address mapped to word 0.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_wb_en_in  in  1  writeback enable from execute
- mem_r_en_in  in  1  load
- mem_w_en_in  in  1  store
- alu_res_in  in  32  ALU result / effective byte address
- st_val_in  in  32  store data (Rm value)
- dest_in  in  4  destination register
- ready  out  1  1 = upstream may advance; 0 = freeze PC and IF/ID/EX registers
- wb_en_out  out  1  MEM/WB writeback enable
- mem_r_en_out  out  1  MEM/WB load flag (writeback mux select)
- alu_res_out  out  32  MEM/WB ALU result
- mem_data_out  out  32  MEM/WB load data
- dest_out  out  4  MEM/WB destination

Behaviour:
- Reset (rst=0, async):
  - EXE/MEM register, MEM/WB register, FSM and counter all clear.
  - State = IDLE; all outputs 0 except ready.
  - ready = 1, because the cleared EXE/MEM register holds no memory op.
- EXE/MEM register (R): loads all inputs on the edge when ready=1; holds when ready=0.
- memop = R.mem_r | R.mem_w.
- FSM states:
  - IDLE: if memop, next = ACCESS and cnt <= WAIT_CYCLES; otherwise stay IDLE.
  - ACCESS: if cnt != 0, cnt <= cnt-1. If cnt == 0, the access completes this cycle and next = IDLE.
- ready (combinational) = (IDLE & !memop) | (ACCESS & cnt==0).
  - A load/store therefore occupies R for WAIT_CYCLES+2 cycles.
  - A non-memory op occupies R for 1 cycle.
- Word index = ((R.alu_res - BASE_ADDR) >> 2) modulo MEM_DEPTH.
  - Low 2 address bits are ignored.
  - Out-of-range addresses wrap; no fault is raised.
- Store: array word written on the completing edge (ACCESS, cnt==0) with R.st_val.
- Load: array read combinationally. mem_data_out captures the array word on the completing edge.
- Both mem_r and mem_w set: treated as load; no write occurs.
- MEM/WB register:
  - When ready=1: loads R.wb_en, R.mem_r, R.alu_res, R.dest, and the read data (0 when not a load).
  - When ready=0: loads a bubble (wb_en_out=0, mem_r_en_out=0; the other fields keep their last values).
- Latency (input edge to MEM/WB output):
  - Non-memory op: 2 edges.
  - Memory op: WAIT_CYCLES+3 edges.
- Back-to-back memory ops: the second is captured on the completing edge of the first and then starts its own IDLE→ACCESS sequence. No overlap, no lost op.
- Reset mid-access: the in-flight store is NOT performed; the array contents are otherwise retained. Reset does not clear memory.

Optional Feature:
- Macro: MEM_FWD_OUT_EN.
- Defined: adds three outputs driven combinationally from R, for the forwarding unit:
  - fwd_wb_en (1): R.wb_en & !R.mem_r. Load data is not yet available, so a load never forwards from this stage.
  - fwd_dest (4): R.dest.
  - fwd_val (32): R.alu_res.
- Undefined: these ports do not exist and there is no other difference.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, ACCESS).
  - WORD_W=32 and REG_ADDR_W=4.
  - Default BASE_ADDR.
- Sub-module data_mem: MEM_DEPTH x 32 array with synchronous write and asynchronous read.
  - Instantiated once.
  - No reset on the array.

Test Plan:
- Reset then idle: rst low mid-simulation → all outputs 0, ready=1 immediately (async). Release, no ops → ready stays 1.
- ALU op passthrough: wb_en=1, alu_res=0x0000002A, dest=5 → two edges later wb_en_out=1, alu_res_out=0x2A, dest_out=5, mem_r_en_out=0; ready never drops.
- Store then load, WAIT_CYCLES=3:
  - Store 0xDEADBEEF to 1028 → ready low 4 cycles.
  - Load from 1028, dest=7 → mem_data_out=0xDEADBEEF, mem_r_en_out=1, dest_out=7 at edge 6 after capture. Bubbles (wb_en_out=0) appear during the stall.
- Wrap and boundary:
  - Store 0x11 to 1024+4*63; load from that address → 0x11.
  - Store 0x22 to 1024+4*64; load from 1024 → 0x22.
  - Address 1025 is treated as 1024.
- Reset mid-store: assert rst during ACCESS with cnt=1 → the later load of that address returns the old value; ready=1 and FSM IDLE after release.
- With MEM_FWD_OUT_EN: ALU op in R (dest=3, alu_res=9) → fwd_wb_en=1, fwd_dest=3, fwd_val=9. Load in R → fwd_wb_en=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage (mem_stage).
// Holds the FSM state enum, the data-path widths, the default base address
// of the data memory, and the packed layouts of the EXE/MEM and MEM/WB
// pipeline registers.
package mem_stage_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;

  // Byte address that maps onto word 0 of the data memory.
  localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'd1024;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r;
    logic                  mem_w;
    logic [WORD_W-1:0]     alu_res;
    logic [WORD_W-1:0]     st_val;
    logic [REG_ADDR_W-1:0] dest;
  } exmem_t;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r;
    logic [WORD_W-1:0]     alu_res;
    logic [WORD_W-1:0]     mem_data;
    logic [REG_ADDR_W-1:0] dest;
  } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bus between the execute stage, mem_stage and the writeback stage.
//   *_in       : EXE -> MEM operation fields (load/store/ALU result)
//   ready      : MEM -> upstream stall control (0 = freeze)
//   *_out      : MEM/WB register contents
//   fwd_*      : forwarding taps from the EXE/MEM register, present only
//                when MEM_FWD_OUT_EN is defined
// modport master: the side driving the operation (execute stage / bench).
// modport slave : mem_stage itself.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                  mem_wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic [WORD_W-1:0]     alu_res_in;
  logic [WORD_W-1:0]     st_val_in;
  logic [REG_ADDR_W-1:0] dest_in;

  logic                  ready;
  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic [WORD_W-1:0]     alu_res_out;
  logic [WORD_W-1:0]     mem_data_out;
  logic [REG_ADDR_W-1:0] dest_out;

`ifdef MEM_FWD_OUT_EN
  logic                  fwd_wb_en;
  logic [REG_ADDR_W-1:0] fwd_dest;
  logic [WORD_W-1:0]     fwd_val;
`endif

  modport master (
    output mem_wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, st_val_in, dest_in,
    input  ready, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out
`ifdef MEM_FWD_OUT_EN
    , input fwd_wb_en, fwd_dest, fwd_val
`endif
  );

  modport slave (
    input  mem_wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, st_val_in, dest_in,
    output ready, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out
`ifdef MEM_FWD_OUT_EN
    , output fwd_wb_en, fwd_dest, fwd_val
`endif
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// data_mem: DEPTH x 32-bit word array with one shared address port.
// Synchronous write, asynchronous (combinational) read, no reset so the
// contents survive a pipeline reset.
//   clk_i   : clock
//   we_i    : write enable (word written on the rising edge)
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data of addr_i
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage ARM pipeline.
// Holds the EXE/MEM register, performs word loads/stores against an internal
// data memory with WAIT_CYCLES extra access cycles, drives the MEM/WB
// register and stalls upstream (ready=0) while an access is in flight.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset (memory contents are kept)
//   bus : mem_stage_if.slave (operation in, ready, MEM/WB out, fwd taps)
// Optional: define MEM_FWD_OUT_EN to add the fwd_wb_en/fwd_dest/fwd_val taps.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 3,
  parameter int unsigned       MEM_DEPTH   = 64,
  parameter logic [WORD_W-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;

  logic              memop;
  logic              ready;
  logic              complete;
  logic              mem_we;
  logic [AW-1:0]     word_idx;
  logic [WORD_W-1:0] rdata;

  assign memop    = exmem_q.mem_r | exmem_q.mem_w;
  assign complete = (state_q == ST_ACCESS) && (cnt_q == '0);
  // A load that also has mem_w set is a plain load: never write.
  assign mem_we   = complete & exmem_q.mem_w & ~exmem_q.mem_r;
  // Low two address bits drop out; out-of-range addresses wrap modulo depth.
  assign word_idx = AW'((exmem_q.alu_res - BASE_ADDR) >> 2);

  data_mem #(
    .DEPTH (MEM_DEPTH)
  ) u_data_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (word_idx),
    .wdata_i (exmem_q.st_val),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = ~memop;
        if (memop) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exmem_d = exmem_q;
    if (ready) begin
      exmem_d.wb_en   = bus.mem_wb_en_in;
      exmem_d.mem_r   = bus.mem_r_en_in;
      exmem_d.mem_w   = bus.mem_w_en_in;
      exmem_d.alu_res = bus.alu_res_in;
      exmem_d.st_val  = bus.st_val_in;
      exmem_d.dest    = bus.dest_in;
    end
  end

  // While stalled a bubble goes down the pipe: enables drop, data fields hold.
  always_comb begin
    memwb_d       = memwb_q;
    memwb_d.wb_en = 1'b0;
    memwb_d.mem_r = 1'b0;
    if (ready) begin
      memwb_d.wb_en    = exmem_q.wb_en;
      memwb_d.mem_r    = exmem_q.mem_r;
      memwb_d.alu_res  = exmem_q.alu_res;
      memwb_d.dest     = exmem_q.dest;
      memwb_d.mem_data = exmem_q.mem_r ? rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.ready        = ready;
  assign bus.wb_en_out    = memwb_q.wb_en;
  assign bus.mem_r_en_out = memwb_q.mem_r;
  assign bus.alu_res_out  = memwb_q.alu_res;
  assign bus.mem_data_out = memwb_q.mem_data;
  assign bus.dest_out     = memwb_q.dest;

`ifdef MEM_FWD_OUT_EN
  // Load data is not available yet, so a load never forwards from here.
  assign bus.fwd_wb_en = exmem_q.wb_en & ~exmem_q.mem_r;
  assign bus.fwd_dest  = exmem_q.dest;
  assign bus.fwd_val   = exmem_q.alu_res;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int unsigned WAIT  = 3;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(
    .WAIT_CYCLES (WAIT),
    .MEM_DEPTH   (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Transaction-level reference: an op in the EXE/MEM register retires at a
  // known edge number; everything else follows from that.
  logic [31:0] mem_m [DEPTH];
  op_t         cur;
  int unsigned edge_n    = 0;
  int unsigned done_edge = 1;
  logic        exp_ready, exp_wb, exp_mr;
  logic [31:0] exp_alu, exp_data;
  logic [3:0]  exp_dest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic wb, input logic mr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] st,
                             input logic [3:0] dest);
    op_t o;
    o.wb = wb; o.mr = mr; o.mw = mw; o.alu = alu; o.st = st; o.dest = dest;
    return o;
  endfunction

  task automatic drive(input op_t op);
    bus.mem_wb_en_in = op.wb;
    bus.mem_r_en_in  = op.mr;
    bus.mem_w_en_in  = op.mw;
    bus.alu_res_in   = op.alu;
    bus.st_val_in    = op.st;
    bus.dest_in      = op.dest;
  endtask

  task automatic model_reset();
    cur       = '0;
    done_edge = edge_n + 1;
    exp_ready = 1'b1;
    exp_wb = 1'b0; exp_mr = 1'b0;
    exp_alu = '0; exp_data = '0; exp_dest = '0;
  endtask

  task automatic model_edge(input op_t op, output bit acc);
    int unsigned idx;
    logic [31:0] off;
    edge_n++;
    acc = (edge_n == done_edge);
    if (acc) begin
      off      = cur.alu - BASE;
      idx      = (off / 4) % DEPTH;
      exp_wb   = cur.wb;
      exp_mr   = cur.mr;
      exp_alu  = cur.alu;
      exp_dest = cur.dest;
      exp_data = cur.mr ? mem_m[idx] : 32'h0;
      if (cur.mw && !cur.mr) mem_m[idx] = cur.st;
      cur       = op;
      done_edge = edge_n + ((op.mr || op.mw) ? WAIT + 2 : 1);
    end else begin
      exp_wb = 1'b0;
      exp_mr = 1'b0;
    end
    exp_ready = (done_edge == edge_n + 1);
  endtask

  task automatic check_outputs();
    chk("ready",        32'(bus.ready),        32'(exp_ready));
    chk("wb_en_out",    32'(bus.wb_en_out),    32'(exp_wb));
    chk("mem_r_en_out", 32'(bus.mem_r_en_out), 32'(exp_mr));
    chk("alu_res_out",  bus.alu_res_out,       exp_alu);
    chk("mem_data_out", bus.mem_data_out,      exp_data);
    chk("dest_out",     32'(bus.dest_out),     32'(exp_dest));
`ifdef MEM_FWD_OUT_EN
    chk("fwd_wb_en", 32'(bus.fwd_wb_en), 32'(cur.wb & ~cur.mr));
    chk("fwd_dest",  32'(bus.fwd_dest),  32'(cur.dest));
    chk("fwd_val",   bus.fwd_val,        cur.alu);
`endif
  endtask

  task automatic cycle(input op_t op, output bit acc);
    drive(op);
    @(posedge clk);
    model_edge(op, acc);
    #1;
    check_outputs();
  endtask

  task automatic issue(input op_t op, output int n);
    bit acc;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      cycle(op, acc);
      n++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $error("FAIL issue_timeout: observed not accepted expected accepted within 40 cycles");
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] val);
    int n;
    issue(mk(1'b0, 1'b0, 1'b1, addr, val, 4'd0), n);
  endtask

  // Issues a load and then a nop; when the nop is accepted the load has
  // just landed in MEM/WB.
  task automatic load(input logic [31:0] addr, input logic [3:0] dest, output logic [31:0] data);
    int n;
    issue(mk(1'b1, 1'b1, 1'b0, addr, 32'h0, dest), n);
    issue('0, n);
    data = bus.mem_data_out;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    drive('0);
    #1;
    model_reset();
    check_outputs();
    chk("rst_ready_async", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    int          n;
    bit          acc;
    logic [31:0] d;
    op_t         op;

    drive('0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b1;
    repeat (3) cycle('0, acc);

    for (int unsigned i = 0; i < DEPTH; i++) store(BASE + 4 * i, $urandom());
    repeat (2) cycle('0, acc);

    // ALU passthrough: visible in MEM/WB one edge after capture
    issue(mk(1'b1, 1'b0, 1'b0, 32'h2A, 32'h0, 4'd5), n);
    cycle('0, acc);
    chk("alu_wb_en",  32'(bus.wb_en_out),    32'd1);
    chk("alu_res",    bus.alu_res_out,       32'h2A);
    chk("alu_dest",   32'(bus.dest_out),     32'd5);
    chk("alu_mem_r",  32'(bus.mem_r_en_out), 32'd0);

    // store then load
    issue(mk(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0), n);
    issue(mk(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd7), n);
    chk("store_stall_cycles", 32'(n), 32'(WAIT + 2));
    issue('0, n);
    chk("load_stall_cycles", 32'(n), 32'(WAIT + 2));
    chk("load_data",  bus.mem_data_out,      32'hDEADBEEF);
    chk("load_mem_r", 32'(bus.mem_r_en_out), 32'd1);
    chk("load_dest",  32'(bus.dest_out),     32'd7);

    // top word, wrap past the end, ignored low address bits
    store(BASE + 4 * 63, 32'h11);
    load(BASE + 4 * 63, 4'd1, d);
    chk("top_word", d, 32'h11);
    store(BASE + 4 * 64, 32'h22);
    load(BASE, 4'd2, d);
    chk("wrap_word0", d, 32'h22);
    load(BASE + 1, 4'd3, d);
    chk("low_bits_ignored", d, 32'h22);

    // both mem_r and mem_w: behaves as a load, no write
    issue(mk(1'b1, 1'b1, 1'b1, BASE + 4 * 63, 32'h99, 4'd4), n);
    load(BASE + 4 * 63, 4'd4, d);
    chk("rw_is_load", d, 32'h11);

    // reset with a store in flight at cnt==1
    store(32'd1040, 32'h55);
    issue(mk(1'b0, 1'b0, 1'b1, 32'd1040, 32'hAA, 4'd0), n);
    repeat (3) cycle('0, acc);
    async_reset();
    repeat (2) cycle('0, acc);
    load(32'd1040, 4'd6, d);
    chk("reset_drops_store", d, 32'h55);

`ifdef MEM_FWD_OUT_EN
    issue(mk(1'b1, 1'b0, 1'b0, 32'd9, 32'h0, 4'd3), n);
    chk("fwd_alu_wb", 32'(bus.fwd_wb_en), 32'd1);
    chk("fwd_alu_dest", 32'(bus.fwd_dest), 32'd3);
    chk("fwd_alu_val", bus.fwd_val, 32'd9);
    issue(mk(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'd3), n);
    chk("fwd_load_wb", 32'(bus.fwd_wb_en), 32'd0);
`endif

    // randomized mix against the reference
    for (int i = 0; i < 200; i++) begin
      int unsigned kind;
      kind  = $urandom_range(0, 5);
      op.wb = 1'($urandom_range(0, 1));
      op.mr = (kind == 1 || kind == 2 || kind == 5);
      op.mw = (kind == 3 || kind == 4 || kind == 5);
      op.alu = ($urandom_range(0, 9) == 0) ? $urandom()
                                           : BASE + $urandom_range(0, 8 * DEPTH - 1);
      op.st   = $urandom();
      op.dest = 4'($urandom_range(0, 15));
      if (kind == 0 && $urandom_range(0, 1) == 1) op = '0;
      issue(op, n);
    end
    repeat (WAIT + 4) cycle('0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
